// File: rtl/dct_transpose.sv
// dct_transpose: ping-pong 8x8 transpose buffer between the DCT row and column passes.
// Rows are written into one bank while the other bank is read out column by column.
module dct_transpose #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    input  logic [W-1:0] i4,
    input  logic [W-1:0] i5,
    input  logic [W-1:0] i6,
    input  logic [W-1:0] i7,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] o0,
    output logic [W-1:0] o1,
    output logic [W-1:0] o2,
    output logic [W-1:0] o3,
    output logic [W-1:0] o4,
    output logic [W-1:0] o5,
    output logic [W-1:0] o6,
    output logic [W-1:0] o7,
    output logic [2:0]   out_col,
    output logic         out_last
);
    logic [W-1:0] mem_q [2][8][8];
    logic [W-1:0] row [8];
    logic [W-1:0] col [8];
    logic         wb_q, wb_d, rb_q, rb_d;
    logic [2:0]   wr_row_q, wr_row_d, rd_col_q, rd_col_d;
    logic [1:0]   full_q, full_d;
    logic         wr, rd, wr_done, rd_done;

    assign row = '{i0, i1, i2, i3, i4, i5, i6, i7};

    // A bank is filled only while empty and drained only while full, so the
    // write and read sides can never touch the same bank in one cycle.
    always_comb begin
        in_ready  = en & ~reset & ~full_q[wb_q];
        out_valid = en & ~reset & full_q[rb_q];
        wr        = in_valid & in_ready;
        rd        = out_valid & out_ready;
        wr_done   = wr & (wr_row_q == 3'd7);
        rd_done   = rd & (rd_col_q == 3'd7);
        wr_row_d  = wr_row_q + 3'(wr);
        rd_col_d  = rd_col_q + 3'(rd);
        wb_d      = wb_q ^ wr_done;
        rb_d      = rb_q ^ rd_done;
        full_d    = full_q;
        if (wr_done) full_d[wb_q] = 1'b1;
        if (rd_done) full_d[rb_q] = 1'b0;
        for (int k = 0; k < 8; k++) col[k] = out_valid ? mem_q[rb_q][k][rd_col_q] : '0;
    end

    assign out_col  = rd_col_q;
    assign out_last = out_valid & (rd_col_q == 3'd7);
    assign o0 = col[0];
    assign o1 = col[1];
    assign o2 = col[2];
    assign o3 = col[3];
    assign o4 = col[4];
    assign o5 = col[5];
    assign o6 = col[6];
    assign o7 = col[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q     <= 1'b0;
            rb_q     <= 1'b0;
            wr_row_q <= '0;
            rd_col_q <= '0;
            full_q   <= '0;
        end else begin
            wb_q     <= wb_d;
            rb_q     <= rb_d;
            wr_row_q <= wr_row_d;
            rd_col_q <= rd_col_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            for (int k = 0; k < 8; k++) mem_q[wb_q][wr_row_q][k] <= row[k];
        end
    end
endmodule

// File: tb/tb_dct_transpose.sv
// tb_dct_transpose: table vectors, directed corner sequences and random traffic
// checked against a block-queue model of the transpose buffer.
module tb_dct_transpose;
    localparam int W = 32;

    logic         clk = 1'b0, reset = 1'b1, en = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] rows [8];
    logic [W-1:0] o [8];
    logic         in_ready, out_valid, out_last;
    logic [2:0]   out_col;

    always #5 clk = ~clk;

    dct_transpose #(.W(W)) dut (
        .clk(clk), .reset(reset), .en(en),
        .in_valid(in_valid), .in_ready(in_ready),
        .i0(rows[0]), .i1(rows[1]), .i2(rows[2]), .i3(rows[3]),
        .i4(rows[4]), .i5(rows[5]), .i6(rows[6]), .i7(rows[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .o0(o[0]), .o1(o[1]), .o2(o[2]), .o3(o[3]),
        .o4(o[4]), .o5(o[5]), .o6(o[6]), .o7(o[7]),
        .out_col(out_col), .out_last(out_last)
    );

    int n_vec = 0, n_bad = 0, cyc_no = 0;

    // Model: completed blocks queued as 64 row-major words each, oldest first.
    logic [W-1:0] mq [$];
    logic [W-1:0] part [64];
    int           prow = 0, pcol = 0;
    logic [261:0] last_act;

    typedef struct {
        logic         vld, rdy;
        logic [W-1:0] base;
        logic         e_ir, e_ov;
        logic [2:0]   e_col;
        logic         e_last;
        logic [W-1:0] e_o0, e_o7;
    } vec_t;
    vec_t tv [16];
    int   t0 [$];

    task automatic check(input string name, input logic [261:0] a, input logic [261:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    task automatic set_rows(input logic [W-1:0] base);
        for (int k = 0; k < 8; k++) rows[k] = base + W'(k);
    endtask

    // Compare every output with the model, then clock once and advance the model.
    task automatic step(input string name);
        logic         ir, ov;
        logic [261:0] e;
        #1;
        ir = en & ~reset & (mq.size() < 128);
        ov = en & ~reset & (mq.size() >= 64);
        e  = {ir, ov, 3'(pcol), ov & (pcol == 7), 256'd0};
        if (ov) for (int k = 0; k < 8; k++) e[W*(7-k) +: W] = mq[8*k+pcol];
        last_act = {in_ready, out_valid, out_col, out_last, o[0], o[1], o[2], o[3], o[4], o[5], o[6], o[7]};
        check(name, last_act, e);
        @(posedge clk);
        if (reset) begin
            mq.delete();
            prow = 0;
            pcol = 0;
        end else begin
            if (ir && in_valid) begin
                for (int k = 0; k < 8; k++) part[8*prow+k] = rows[k];
                prow++;
                if (prow == 8) begin
                    prow = 0;
                    for (int j = 0; j < 64; j++) mq.push_back(part[j]);
                end
            end
            if (ov && out_ready) begin
                pcol++;
                if (pcol == 8) begin
                    pcol = 0;
                    repeat (64) void'(mq.pop_front());
                end
            end
        end
        @(negedge clk);
        cyc_no++;
    endtask

    initial begin
        logic [261:0] prev;
        int           idle;
        logic [W-1:0] spec [4];
        spec = '{32'h7FC00000, 32'h80000000, 32'h00000001, 32'h3F800000};

        for (int i = 0; i < 8; i++)
            tv[i] = '{1'b1, 1'b1, W'(8*i), 1'b1, 1'b0, 3'd0, 1'b0, '0, '0};
        for (int c = 0; c < 8; c++)
            tv[8+c] = '{1'b0, 1'b1, '0, 1'b1, 1'b1, 3'(c), 1'(c == 7), W'(c), W'(56+c)};

        set_rows('0);
        @(negedge clk);
        en = 1'b1;
        step("reset0");
        step("reset1");
        reset = 1'b0;

        // single block from the table
        for (int i = 0; i < 16; i++) begin
            in_valid  = tv[i].vld;
            out_ready = tv[i].rdy;
            set_rows(tv[i].base);
            step("blk_model");
            check("blk_table",
                  262'({last_act[261:256], last_act[255:224], last_act[31:0]}),
                  262'({tv[i].e_ir, tv[i].e_ov, tv[i].e_col, tv[i].e_last, tv[i].e_o0, tv[i].e_o7}));
        end
        in_valid = 1'b0;
        step("blk_after");

        // three back-to-back blocks
        idle = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 34; i++) begin
            if (i == 24) in_valid = 1'b0;
            set_rows(W'(8*i));
            step("stream");
            if (i < 24 && !last_act[261]) idle++;
            if (last_act[260] && last_act[259:257] == 3'd0) t0.push_back(cyc_no);
        end
        check("stream_ready_drops", 262'(idle), 262'(0));
        check("stream_blocks", 262'(t0.size()), 262'(3));
        if (t0.size() >= 3) begin
            check("stream_gap1", 262'(t0[1] - t0[0]), 262'(8));
            check("stream_gap2", 262'(t0[2] - t0[1]), 262'(8));
        end

        // backpressure: two blocks buffered with no reads
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int r = 0; r < 16; r++) begin
            set_rows(W'(1000 + 8*r));
            step("bp_fill");
        end
        step("bp_full");
        check("bp_in_ready", 262'(last_act[261]), 262'(0));
        prev = last_act;
        in_valid = 1'b0;
        step("bp_stall");
        check("bp_stable", last_act, prev);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) step("bp_read");
        step("bp_free");
        check("bp_ready_back", 262'(last_act[261]), 262'(1));
        for (int c = 0; c < 8; c++) step("bp_read2");

        // enable gap after row 3
        in_valid = 1'b1;
        for (int r = 0; r < 8; r++) begin
            set_rows(W'(2000 + 8*r));
            step("en_row");
            if (r == 3) begin
                en = 1'b0;
                for (int g = 0; g < 5; g++) begin
                    step("en_gap");
                    check("en_gap_hs", 262'(last_act[261:260]), 262'(0));
                end
                en = 1'b1;
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 9; c++) step("en_read");

        // reset after five rows
        in_valid = 1'b1;
        for (int r = 0; r < 5; r++) begin
            set_rows(W'(3000 + 8*r));
            step("rst_part");
        end
        reset = 1'b1;
        step("rst_pulse");
        reset = 1'b0;
        in_valid = 1'b0;
        step("rst_after");
        check("rst_hs", 262'(last_act[261:260]), 262'(2'b10));
        in_valid = 1'b1;
        for (int r = 0; r < 8; r++) begin
            set_rows(W'(4000 + 8*r));
            step("rst_fresh");
        end
        in_valid = 1'b0;
        for (int c = 0; c < 9; c++) step("rst_read");

        // special float encodings pass unchanged
        in_valid = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) rows[k] = spec[(r + k) % 4];
            step("bits_row");
        end
        in_valid = 1'b0;
        step("bits_col0");
        check("bits_nan", 262'(last_act[255:224]), 262'(32'h7FC00000));
        for (int c = 0; c < 8; c++) step("bits_read");

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            en        = ($urandom_range(0, 9) != 0);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom_range(0, 3) != 0);
            for (int k = 0; k < 8; k++) rows[k] = $urandom;
            step("rand");
        end
        reset = 1'b0;
        en = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
